// File: rtl/dcp_tx_arb.sv
`default_nettype none
// =============================================================================
// Module      : dcp_tx_arb
// Description : Round-robin arbiter sharing one transmitter among NREQ command
//               handlers, with a per-grant BUSY watchdog.
// Revision    : 1.0 - initial release
// =============================================================================
module dcp_tx_arb #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 1000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_i,
    input  logic [NREQ-1:0]      type_i,
    input  logic [32*NREQ-1:0]   dout_i,
    output logic [NREQ-1:0]      ack_o,
    output logic                 req_tx,
    output logic                 type_tx,
    output logic [31:0]          dout_tx,
    input  logic                 ack_tx,
    output logic [NREQ-1:0]      grant,
    output logic                 busy,
    output logic                 err_timeout,
    output logic [7:0]           xfer_cnt
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NREQ - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [IW-1:0]   last_winner;
    logic [IW-1:0]   win_idx;
    logic [IW-1:0]   cand;
    logic            win_found;
    logic [NREQ-1:0] win_onehot;
    logic            win_type;
    logic [31:0]     win_dout;
    logic [TW-1:0]   timer;
    logic            ack_hit;
    logic            tmo_hit;

    // Search starts just past the previous winner so every requester gets a turn.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = IW'((int'(last_winner) + 1 + i) % NREQ);
            if (!win_found && req_i[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        win_onehot = '0;
        win_type   = 1'b0;
        win_dout   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (win_idx == IW'(k)) begin
                win_onehot[k] = win_found;
                win_type      = type_i[k];
                win_dout      = dout_i[k*32 +: 32];
            end
        end
    end

    // An ack in the final watchdog cycle takes priority over the abort.
    assign ack_hit = (state == ST_BUSY) && ack_tx;
    assign tmo_hit = (state == ST_BUSY) && !ack_tx && (timer == TMO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != ST_IDLE);
        ack_o     = ack_hit ? grant : '0;
        case (state)
            ST_IDLE:    if (win_found) state_nxt = ST_BUSY;
            ST_BUSY:    if (ack_hit || tmo_hit) state_nxt = ST_RELEASE;
            ST_RELEASE: state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant       <= '0;
            type_tx     <= 1'b0;
            dout_tx     <= '0;
            req_tx      <= 1'b0;
            err_timeout <= 1'b0;
            xfer_cnt    <= '0;
            timer       <= '0;
            last_winner <= LAST_IDX;
        end else begin
            err_timeout <= tmo_hit;
            case (state)
                ST_IDLE: begin
                    if (win_found) begin
                        grant       <= win_onehot;
                        type_tx     <= win_type;
                        dout_tx     <= win_dout;
                        last_winner <= win_idx;
                        req_tx      <= 1'b1;
                        timer       <= '0;
                    end
                end
                ST_BUSY: begin
                    timer <= timer + 1'b1;
                    if (ack_hit || tmo_hit) req_tx <= 1'b0;
                    if (ack_hit) xfer_cnt <= xfer_cnt + 8'd1;
                end
                ST_RELEASE: grant <= '0;
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dcp_tx_arb.sv
`default_nettype none
// =============================================================================
// Module      : tb_dcp_tx_arb
// Description : Directed scoreboard bench for dcp_tx_arb (NREQ=4, TIMEOUT=8).
// Revision    : 1.0 - initial release
// =============================================================================
module tb_dcp_tx_arb;
    localparam int NREQ = 4;
    localparam int TMO  = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req_i = '0;
    logic [NREQ-1:0]   type_i = '0;
    logic [32*NREQ-1:0] dout_i = '0;
    logic [NREQ-1:0]   ack_o;
    logic              req_tx;
    logic              type_tx;
    logic [31:0]       dout_tx;
    logic              ack_tx = 1'b0;
    logic [NREQ-1:0]   grant;
    logic              busy;
    logic              err_timeout;
    logic [7:0]        xfer_cnt;

    dcp_tx_arb #(.NREQ(NREQ), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .type_i(type_i), .dout_i(dout_i),
        .ack_o(ack_o), .req_tx(req_tx), .type_tx(type_tx), .dout_tx(dout_tx),
        .ack_tx(ack_tx), .grant(grant), .busy(busy), .err_timeout(err_timeout),
        .xfer_cnt(xfer_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [7:0] cnt_exp = '0;

    typedef struct packed {
        logic [3:0]  g;
        logic        t;
        logic [31:0] d;
    } sb_t;
    sb_t sbq[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int k);
        sb_t e;
        e.g = 4'(1 << k);
        e.t = type_i[k];
        e.d = dout_i[k*32 +: 32];
        sbq.push_back(e);
    endtask

    task automatic reset_dut();
        rst    = 1'b1;
        req_i  = '0;
        ack_tx = 1'b0;
        @(negedge clk);
        rst     = 1'b0;
        cnt_exp = '0;
        sbq.delete();
    endtask

    // Waits for the next grant, checks it against the scoreboard head, then
    // either acks after dly further BUSY cycles or lets the watchdog expire.
    task automatic serve(input string tag, input int lat, input int dly,
                         input bit do_ack, input bit mutate);
        sb_t e;
        int n;
        logic [32*NREQ-1:0] saved;
        n = 0;
        while (req_tx !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_lat"}, 64'(n), 64'(lat));
        chk({tag, "_sb"}, 64'(sbq.size() != 0), 64'd1);
        if (sbq.size() == 0) return;
        e = sbq.pop_front();
        chk({tag, "_grant"}, 64'(grant), 64'(e.g));
        chk({tag, "_type"}, 64'(type_tx), 64'(e.t));
        chk({tag, "_dout"}, 64'(dout_tx), 64'(e.d));
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        if (do_ack) begin
            saved = dout_i;
            if (mutate) dout_i = ~dout_i;
            repeat (dly) begin
                @(negedge clk);
                chk({tag, "_hold"}, 64'(dout_tx), 64'(e.d));
                chk({tag, "_early_ack"}, 64'(ack_o), 64'd0);
            end
            dout_i = saved;
            ack_tx = 1'b1;
            #1;
            chk({tag, "_ack"}, 64'(ack_o), 64'(e.g));
            cnt_exp++;
            @(negedge clk);
            ack_tx = 1'b0;
            chk({tag, "_ack_end"}, 64'(ack_o), 64'd0);
            chk({tag, "_reqtx_off"}, 64'(req_tx), 64'd0);
            chk({tag, "_rel_busy"}, 64'(busy), 64'd1);
            chk({tag, "_rel_grant"}, 64'(grant), 64'(e.g));
            chk({tag, "_noerr"}, 64'(err_timeout), 64'd0);
            chk({tag, "_cnt"}, 64'(xfer_cnt), 64'(cnt_exp));
        end else begin
            n = 1;
            while (req_tx === 1'b1 && n <= 20) begin
                chk({tag, "_no_ack"}, 64'(ack_o), 64'd0);
                @(negedge clk);
                if (req_tx === 1'b1) n++;
            end
            chk({tag, "_busy_cycles"}, 64'(n), 64'(TMO));
            chk({tag, "_err"}, 64'(err_timeout), 64'd1);
            chk({tag, "_cnt"}, 64'(xfer_cnt), 64'(cnt_exp));
            chk({tag, "_rel_busy"}, 64'(busy), 64'd1);
            @(negedge clk);
            chk({tag, "_err_pulse"}, 64'(err_timeout), 64'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_req_tx", 64'(req_tx), 64'd0);
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ack_o", 64'(ack_o), 64'd0);
        chk("rst_err", 64'(err_timeout), 64'd0);
        chk("rst_cnt", 64'(xfer_cnt), 64'd0);
        chk("rst_dout", 64'(dout_tx), 64'd0);
        chk("rst_type", 64'(type_tx), 64'd0);
        rst = 1'b0;

        // Single requester 2, ack three cycles into BUSY.
        @(negedge clk);
        type_i = 4'b0100;
        dout_i = {32'h0, 32'h1357_9bdf, 32'h0, 32'h0};
        req_i  = 4'b0100;
        push(2);
        serve("single", 1, 3, 1'b1, 1'b0);
        req_i = '0;

        // Stray ack while idle.
        @(negedge clk);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_grant", 64'(grant), 64'd0);
        ack_tx = 1'b1;
        #1;
        chk("idle_ack_o", 64'(ack_o), 64'd0);
        @(negedge clk);
        ack_tx = 1'b0;
        chk("idle_cnt", 64'(xfer_cnt), 64'd1);
        chk("idle_req_tx", 64'(req_tx), 64'd0);

        // Reset in the middle of a transfer.
        type_i = 4'b1000;
        dout_i = {32'hdead_beef, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        req_i  = 4'b1000;
        @(negedge clk);
        chk("pre_rst_grant", 64'(grant), 64'h8);
        chk("pre_rst_req_tx", 64'(req_tx), 64'd1);
        rst    = 1'b1;
        ack_tx = 1'b1;
        #1;
        chk("mid_rst_req_tx", 64'(req_tx), 64'd0);
        chk("mid_rst_grant", 64'(grant), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_ack_o", 64'(ack_o), 64'd0);
        chk("mid_rst_cnt", 64'(xfer_cnt), 64'd0);
        @(negedge clk);
        rst     = 1'b0;
        ack_tx  = 1'b0;
        cnt_exp = '0;
        req_i   = 4'b1001;
        push(0);
        serve("post_rst", 1, 1, 1'b1, 1'b0);
        req_i = '0;

        // All four requesting: round-robin order, data held while changed.
        reset_dut();
        type_i = 4'b1010;
        dout_i = {32'hd0d0_0003, 32'hc0c0_0002, 32'hb0b0_0001, 32'ha0a0_0000};
        req_i  = 4'b1111;
        push(0); push(1); push(2); push(3); push(0);
        serve("rr0", 1, 1, 1'b1, 1'b0);
        serve("rr1", 2, 1, 1'b1, 1'b1);
        serve("rr2", 2, 1, 1'b1, 1'b0);
        serve("rr3", 2, 1, 1'b1, 1'b0);
        serve("rr4", 2, 1, 1'b1, 1'b0);
        req_i = '0;
        chk("rr_total", 64'(xfer_cnt), 64'd5);

        // Watchdog abort on requester 0, then requester 1 acked on the last legal cycle.
        reset_dut();
        type_i = 4'b0010;
        dout_i = {32'h0, 32'h0, 32'h5a5a_0001, 32'h5a5a_0000};
        req_i  = 4'b0011;
        push(0); push(1);
        serve("tmo", 1, 0, 1'b0, 1'b0);
        serve("tmo_next", 1, TMO - 1, 1'b1, 1'b0);
        req_i = '0;
        chk("tmo_total", 64'(xfer_cnt), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dcp_tx_arb.md
DCP_TX_ARB -- requirements
Module: dcp_tx_arb

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of command-handler requesters sharing the transmitter.
REQ-002 SHALL have parameter TIMEOUT, default 1000, max BUSY cycles allowed without ack_tx before abort.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port req_i  input  NREQ  per-requester transmit request, level, held until acked.
REQ-006 SHALL have port type_i  input  NREQ  per-requester transfer type (0 = byte, 1 = word).
REQ-007 SHALL have port dout_i  input  32*NREQ  per-requester data, requester k at bits [32k+31:32k].
REQ-008 SHALL have port ack_o  output  NREQ  per-requester acknowledge, one-hot pulse.
REQ-009 SHALL have port req_tx  output  1  request to transmitter.
REQ-010 SHALL have port type_tx  output  1  latched type of granted transfer.
REQ-011 SHALL have port dout_tx  output  32  latched data of granted transfer.
REQ-012 SHALL have port ack_tx  input  1  transmitter acknowledge, one-cycle pulse.
REQ-013 SHALL have port grant  output  NREQ  one-hot current owner, all zero when idle.
REQ-014 SHALL have port busy  output  1  high in BUSY and RELEASE.
REQ-015 SHALL have port err_timeout  output  1  one-cycle pulse on abort.
REQ-016 SHALL have port xfer_cnt  output  8  count of completed transfers, wraps 8'hFF -> 8'h00.

Function
REQ-017 SHALL implement three states: IDLE, BUSY, RELEASE.
REQ-018 IDLE with any req_i high: SHALL select winner round-robin, searching from index (last_winner+1) mod NREQ upward; move to BUSY next edge.
REQ-019 On the IDLE->BUSY edge SHALL latch grant, type_tx, dout_tx from the winner; these SHALL stay constant for the whole BUSY state regardless of input changes.
REQ-020 req_tx SHALL be registered, high exactly while in BUSY; first req_tx cycle is one cycle after winner's req_i was sampled in IDLE.
REQ-021 In BUSY, ack_tx high: ack_o[winner] SHALL be 1 in that same cycle (combinational), state -> RELEASE, xfer_cnt +1.
REQ-022 ack_o SHALL be all zero outside BUSY; ack_tx outside BUSY SHALL be ignored (no ack_o, no count).
REQ-023 RELEASE SHALL last exactly one cycle, ignore all req_i, then -> IDLE; grant cleared on entry to IDLE.
REQ-024 BUSY timer SHALL clear on BUSY entry, increment each BUSY cycle; at TIMEOUT cycles without ack_tx SHALL pulse err_timeout, drop req_tx, go to RELEASE, no ack_o, no count.
REQ-025 last_winner SHALL update at every grant, including grants ending in timeout, so a stuck requester cannot starve others.
REQ-026 ack_tx arriving in the same cycle the timer reaches TIMEOUT SHALL count as success (ack wins, no error).
REQ-027 Single requester continuously requesting SHALL obtain back-to-back grants, one transfer per minimum 3 cycles (IDLE, BUSY>=1, RELEASE).

Reset
REQ-028 rst high SHALL force immediately: state IDLE, req_tx 0, type_tx 0, dout_tx 0, grant 0, ack_o 0, busy 0, err_timeout 0, xfer_cnt 0, timer 0, last_winner NREQ-1 (so requester 0 has first priority).
REQ-029 rst mid-BUSY SHALL abandon the transfer with no ack_o and no count; first arbitration after release restarts from requester 0.

Verification
REQ-030 Reset release, req_i=4'b0100, type_i[2]=1, dout=32'h1357_9bdf, ack_tx 3 cycles after req_tx -> grant=4'b0100, dout_tx=32'h1357_9bdf, type_tx=1, ack_o=4'b0100 one cycle, xfer_cnt=1.
REQ-031 req_i=4'b1111 held, ack_tx each BUSY after 1 cycle -> grant order 0,1,2,3,0; xfer_cnt=5.
REQ-032 Requester 1 changes dout_i during BUSY -> dout_tx keeps value latched at grant.
REQ-033 TIMEOUT=8, req_i=4'b0011, no ack_tx -> err_timeout pulse after 8 BUSY cycles, no ack_o, next grant to requester 1.
REQ-034 ack_tx pulse while IDLE -> ack_o stays 0, xfer_cnt unchanged.
REQ-035 rst asserted in BUSY -> req_tx, grant, busy 0 same cycle; after release req_i=4'b1001 -> grant=4'b0001 first.
